data_bus_arbiter: RTL

// - Shares the single data-memory port between two requesters: m0 = core MEM stage, m1 = debug/DMA master.
// - Both sides use the req/gnt/rvalid protocol.
// - Round-robin arbitration with one outstanding transaction; read data is returned only to the owner.
// - Read watchdog: recovers the bus if memory never returns rvalid.
// - Sits between core_mem_stage data_* ports and the data RAM/bus.

---
 rtl/data_bus_arbiter_pkg.sv | 20 ++
 rtl/data_arb_watchdog.sv | 34 +++
 rtl/data_bus_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
// Imported by the top level and by its read watchdog.
package data_bus_arbiter_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int BE_W_DEF    = 4;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic {
        ARB_IDLE      = 1'b0,
        ARB_READ_WAIT = 1'b1
    } arb_state_e;

    // A disabled watchdog (timeout 0) still gets a 1-bit counter so no zero-width vectors appear.
    function automatic int wd_cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/data_arb_watchdog.sv
// Read watchdog: counts READ_WAIT cycles without rvalid.
// It flags expiry when the last allowed cycle is reached.
module data_arb_watchdog
    import data_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = wd_cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] MAX  = '1;

    logic [CNT_W-1:0] wd_cnt;

    // The counter saturates instead of wrapping, so a stalled read can never re-arm the compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (clear) begin
            wd_cnt <= '0;
        end else if (run && (wd_cnt != MAX)) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    assign expire = (TIMEOUT_CYC != 0) && run && (wd_cnt == LAST);

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core MEM stage (m0)
// and a debug/DMA master (m1), with a single outstanding read and a read watchdog.
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int BE_W        = BE_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req_i,
    input  logic              m0_wr_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic [BE_W-1:0]   m0_be_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_wr_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic [BE_W-1:0]   m1_be_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic              s_req_o,
    output logic              s_wr_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    output logic [BE_W-1:0]   s_be_o,
    input  logic              s_gnt_i,
    input  logic              s_rvalid_i,
    input  logic [DATA_W-1:0] s_rdata_i,

    output logic              timeout_o
);

    arb_state_e state, next_state;
    logic       rr_ptr;
    logic       lock;
    logic       lock_sel;
    logic       owner;
    logic       sel;
    logic       handshake;
    logic       abort;

    // A stalled request keeps its master selected so memory never sees the request change under it.
    always_comb begin
        sel = rr_ptr;
        if (lock) begin
            sel = lock_sel;
        end else if (m0_req_i && !m1_req_i) begin
            sel = 1'b0;
        end else if (m1_req_i && !m0_req_i) begin
            sel = 1'b1;
        end
    end

    assign s_wr_o    = sel ? m1_wr_i    : m0_wr_i;
    assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
    assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
    assign s_be_o    = sel ? m1_be_i    : m0_be_i;

    assign handshake = s_req_o & s_gnt_i;

    data_arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (handshake),
        .run    ((state == ARB_READ_WAIT) && !s_rvalid_i),
        .expire (abort)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE: begin
                if (handshake && !s_wr_o) begin
                    next_state = ARB_READ_WAIT;
                end
            end
            ARB_READ_WAIT: begin
                if (s_rvalid_i || abort) begin
                    next_state = ARB_IDLE;
                end
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    // A watchdog abort returns zero data; otherwise the memory data is passed to both masters.
    always_comb begin
        s_req_o     = 1'b0;
        m0_gnt_o    = 1'b0;
        m1_gnt_o    = 1'b0;
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m0_rdata_o  = abort ? '0 : s_rdata_i;
        m1_rdata_o  = abort ? '0 : s_rdata_i;
        case (state)
            ARB_IDLE: begin
                s_req_o  = sel ? m1_req_i : m0_req_i;
                m0_gnt_o = s_gnt_i & s_req_o & !sel;
                m1_gnt_o = s_gnt_i & s_req_o & sel;
            end
            ARB_READ_WAIT: begin
                m0_rvalid_o = (s_rvalid_i | abort) & !owner;
                m1_rvalid_o = (s_rvalid_i | abort) & owner;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= 1'b0;
            lock      <= 1'b0;
            lock_sel  <= 1'b0;
            owner     <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= abort;
            if (handshake) begin
                rr_ptr <= ~sel;
                lock   <= 1'b0;
                if (!s_wr_o) begin
                    owner <= sel;
                end
            end else if (s_req_o) begin
                lock     <= 1'b1;
                lock_sel <= sel;
            end
        end
    end

endmodule
